// File: rtl/secuenciador_acumulador_pkg.sv
// secuenciador_acumulador_pkg
//   Shared definitions for the accumulator sequencer: FSM state codes,
//   instruction opcodes, the ALU control codes understood by the
//   Procesamiento datapath, and small decode helpers used by the top level.
//   No ports; imported with "import secuenciador_acumulador_pkg::*;".

package secuenciador_acumulador_pkg;

    // Sequencer states: one instruction walks FETCH -> DECODE -> EXECUTE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    // Opcodes live in the upper nibble of the instruction word.
    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDI   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SUBI  = 4'h3;
    localparam logic [3:0] OP_NANDI = 4'h4;
    localparam logic [3:0] OP_OUT   = 4'h5;
    localparam logic [3:0] OP_JC    = 4'h6;
    localparam logic [3:0] OP_JZ    = 4'h7;
    localparam logic [3:0] OP_JMP   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALU operation codes shared with the datapath.
    localparam logic [2:0] ALU_PASS_A = 3'd0;
    localparam logic [2:0] ALU_SUB    = 3'd1;
    localparam logic [2:0] ALU_PASS_B = 3'd2;
    localparam logic [2:0] ALU_ADD    = 3'd3;
    localparam logic [2:0] ALU_NAND   = 3'd4;

    // True for the immediate instructions that write the accumulator.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_ADDI) ||
               (op == OP_SUBI) || (op == OP_NANDI);
    endfunction

    // ALU control code that goes with an accumulator-writing opcode.
    function automatic logic [2:0] alu_code(input logic [3:0] op);
        logic [2:0] code;
        code = ALU_PASS_A;
        case (op)
            OP_LDI:   code = ALU_PASS_B;
            OP_ADDI:  code = ALU_ADD;
            OP_SUBI:  code = ALU_SUB;
            OP_NANDI: code = ALU_NAND;
            default:  code = ALU_PASS_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/secuenciador_acumulador_contador_pc.sv
// secuenciador_acumulador_contador_pc
//   Program counter for the sequencer. Modulo 2**PC_W, so incrementing
//   past the last ROM word wraps back to address 0.
// Ports
//   clk     in   1     rising-edge clock
//   reset   in   1     asynchronous clear, active low
//   load    in   1     load target (jump); wins over inc
//   inc     in   1     advance to the next word
//   target  in   PC_W  jump destination
//   pc      out  PC_W  current program counter

module secuenciador_acumulador_contador_pc #(
    parameter int PC_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            inc,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (load) begin
            pc <= target;
        end else if (inc) begin
            pc <= pc + PC_W'(1);
        end
    end

endmodule

// File: rtl/secuenciador_acumulador.sv
// secuenciador_acumulador
//   Instruction sequencer for the accumulator/ALU datapath. Reads 8-bit
//   words from a synchronous program ROM and runs each instruction in a
//   fixed FETCH / DECODE / EXECUTE sequence, driving the datapath operand,
//   ALU op, accumulator load strobe and output-buffer enable. Jumps test
//   the carry/zero flags captured on the last accumulator write.
// Ports
//   clk           in   1        rising-edge clock
//   reset         in   1        asynchronous clear, active low
//   start         in   1        starts execution at address 0 from IDLE
//   rom_addr      out  PC_W     program ROM address (the PC)
//   rom_data      in   INSTR_W  ROM word, one cycle after rom_addr
//   dataIn        out  4        operand for the datapath B input
//   control       out  3        ALU operation code
//   enableOutALU  out  1        ALU output buffer enable (OUT)
//   loadAcu       out  1        accumulator load strobe
//   C, Z          in   1        live datapath carry / zero flags
//   running       out  1        executing instructions
//   halted        out  1        stopped on HALT until reset

module secuenciador_acumulador
    import secuenciador_acumulador_pkg::*;
#(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [3:0]         dataIn,
    output logic [2:0]         control,
    output logic               enableOutALU,
    output logic               loadAcu,
    input  logic               C,
    input  logic               Z,
    output logic               running,
    output logic               halted
);

    state_t               state;
    state_t               state_next;
    logic [INSTR_W-1:0]   ir;
    logic [3:0]           opcode;
    logic [3:0]           operand;
    logic [3:0]           fetched_op;
    logic                 cf;
    logic                 zf;
    logic [3:0]           data_q;
    logic [2:0]           ctrl_q;
    logic [PC_W-1:0]      pc;
    logic                 pc_load;
    logic                 pc_inc;
    logic                 load_acu;
    logic                 enable_out;

    assign opcode     = ir[INSTR_W-1 -: 4];
    assign operand    = ir[3:0];
    assign fetched_op = rom_data[INSTR_W-1 -: 4];

    secuenciador_acumulador_contador_pc #(
        .PC_W (PC_W)
    ) u_contador_pc (
        .clk    (clk),
        .reset  (reset),
        .load   (pc_load),
        .inc    (pc_inc),
        .target (PC_W'(operand)),
        .pc     (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The operand and ALU op are registered on the DECODE->EXECUTE edge so
    // they are already valid throughout EXECUTE and then stay put until the
    // next instruction that changes them; the datapath therefore sees stable
    // inputs on both sides of the loadAcu edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir     <= '0;
            data_q <= '0;
            ctrl_q <= ALU_PASS_A;
        end else if (state == ST_DECODE) begin
            ir <= rom_data;
            if (is_alu_op(fetched_op)) begin
                data_q <= rom_data[3:0];
                ctrl_q <= alu_code(fetched_op);
            end else if (fetched_op == OP_OUT) begin
                ctrl_q <= ALU_PASS_A;
            end
        end
    end

    // Flags are captured only when the accumulator is written, so JC/JZ
    // see the result of the last ALU instruction rather than whatever the
    // ALU happens to show at jump time.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cf <= 1'b0;
            zf <= 1'b0;
        end else if (load_acu) begin
            cf <= C;
            zf <= Z;
        end
    end

    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        load_acu   = 1'b0;
        enable_out = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_next = ST_FETCH;
                case (opcode)
                    OP_NOP: begin
                        pc_inc = 1'b1;
                    end
                    OP_LDI, OP_ADDI, OP_SUBI, OP_NANDI: begin
                        load_acu = 1'b1;
                        pc_inc   = 1'b1;
                    end
                    OP_OUT: begin
                        enable_out = 1'b1;
                        pc_inc     = 1'b1;
                    end
                    OP_JC: begin
                        pc_load = cf;
                        pc_inc  = ~cf;
                    end
                    OP_JZ: begin
                        pc_load = zf;
                        pc_inc  = ~zf;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                    end
                    OP_HALT: begin
                        state_next = ST_HALT;
                    end
                    default: begin
                        pc_inc = 1'b1;
                    end
                endcase
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rom_addr     = pc;
    assign dataIn       = data_q;
    assign control      = ctrl_q;
    assign loadAcu      = load_acu;
    assign enableOutALU = enable_out;
    assign running      = (state == ST_FETCH) || (state == ST_DECODE) ||
                          (state == ST_EXECUTE);
    assign halted       = (state == ST_HALT);

endmodule

// File: tb/tb_secuenciador_acumulador.sv
// tb_secuenciador_acumulador
//   Bench for the sequencer: a behavioural synchronous ROM and accumulator
//   datapath around the DUT, an instruction-level reference model, and
//   directed programs with hand-computed results.

module tb_secuenciador_acumulador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic [3:0] dataIn;
    logic [2:0] control;
    logic       enableOutALU;
    logic       loadAcu;
    logic       C;
    logic       Z;
    logic       running;
    logic       halted;

    logic [7:0] rom [16];
    logic [3:0] acc;
    logic [4:0] alu_wide;
    logic [3:0] dataOut;

    int checks = 0;
    int errors = 0;

    // Reference model state: instruction-level interpreter.
    int m_mode = 0;
    int m_cyc  = 0;
    int m_pc   = 0;
    int m_acc  = 0;
    int m_cf   = 0;
    int m_zf   = 0;
    int m_din  = 0;
    int m_ctl  = 0;

    logic       out_seen = 1'b0;
    logic [3:0] out_val  = 4'd0;

    always #5 clk = ~clk;

    secuenciador_acumulador dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .dataIn       (dataIn),
        .control      (control),
        .enableOutALU (enableOutALU),
        .loadAcu      (loadAcu),
        .C            (C),
        .Z            (Z),
        .running      (running),
        .halted       (halted)
    );

    // Synchronous program ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Accumulator datapath: 5-bit ALU result, bit 4 is carry (ADD) or borrow (SUB).
    always_comb begin
        alu_wide = {1'b0, acc};
        case (control)
            3'd0: alu_wide = {1'b0, acc};
            3'd1: alu_wide = {1'b0, acc} - {1'b0, dataIn};
            3'd2: alu_wide = {1'b0, dataIn};
            3'd3: alu_wide = {1'b0, acc} + {1'b0, dataIn};
            3'd4: alu_wide = {1'b0, ~(acc & dataIn)};
            default: alu_wide = {1'b0, acc};
        endcase
    end
    assign C       = alu_wide[4];
    assign Z       = (alu_wide[3:0] == 4'd0);
    assign dataOut = enableOutALU ? alu_wide[3:0] : 4'd0;

    always @(posedge clk or negedge reset) begin
        if (!reset) acc <= 4'd0;
        else if (loadAcu) acc <= alu_wide[3:0];
    end

    function automatic int aluCode(input int op);
        case (op)
            1: return 2;
            2: return 3;
            3: return 1;
            4: return 4;
            default: return 0;
        endcase
    endfunction

    // Carries out one whole instruction on the model at the end of its third cycle.
    task automatic modelExecute();
        int op;
        int k;
        int s;
        op = int'(rom[m_pc][7:4]);
        k  = int'(rom[m_pc][3:0]);
        case (op)
            1: begin m_acc = k; m_cf = 0; end
            2: begin s = m_acc + k; m_cf = (s > 15) ? 1 : 0; m_acc = s % 16; end
            3: begin m_cf = (m_acc < k) ? 1 : 0; m_acc = (m_acc - k + 16) % 16; end
            4: begin m_acc = 15 - (m_acc & k); m_cf = 0; end
            default: ;
        endcase
        if (op >= 1 && op <= 4) begin
            m_zf  = (m_acc == 0) ? 1 : 0;
            m_din = k;
            m_ctl = aluCode(op);
        end
        if (op == 5) m_ctl = 0;
        if (op == 15) m_mode = 2;
        else if (op == 8 || (op == 6 && m_cf == 1) || (op == 7 && m_zf == 1)) m_pc = k;
        else m_pc = (m_pc + 1) % 16;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mode = 0; m_cyc = 0; m_pc = 0; m_acc = 0;
            m_cf = 0; m_zf = 0; m_din = 0; m_ctl = 0;
        end else if (m_mode == 0) begin
            if (start) begin
                m_mode = 1;
                m_cyc  = 0;
            end
        end else if (m_mode == 1) begin
            if (m_cyc < 2) begin
                m_cyc++;
            end else begin
                modelExecute();
                m_cyc = 0;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle compare against the model on every falling edge.
    always @(negedge clk) begin
        logic [7:0] w;
        int op;
        int k;
        logic executing;
        logic e_load;
        logic e_en;
        int e_din;
        int e_ctl;
        w         = rom[m_pc];
        op        = int'(w[7:4]);
        k         = int'(w[3:0]);
        executing = (m_mode == 1) && (m_cyc == 2);
        e_load    = executing && (op >= 1) && (op <= 4);
        e_en      = executing && (op == 5);
        e_din     = e_load ? k : m_din;
        e_ctl     = e_load ? aluCode(op) : (e_en ? 0 : m_ctl);
        checkOutput("rom_addr", 32'(rom_addr), 32'(m_pc));
        checkOutput("running", 32'(running), 32'(m_mode == 1));
        checkOutput("halted", 32'(halted), 32'(m_mode == 2));
        checkOutput("loadAcu", 32'(loadAcu), 32'(e_load));
        checkOutput("enableOutALU", 32'(enableOutALU), 32'(e_en));
        checkOutput("dataIn", 32'(dataIn), 32'(e_din));
        checkOutput("control", 32'(control), 32'(e_ctl));
        if (e_en) checkOutput("dataOut_model", 32'(dataOut), 32'(m_acc));
        if (!reset) begin
            out_seen = 1'b0;
            out_val  = 4'd0;
        end else if (enableOutALU) begin
            out_seen = 1'b1;
            out_val  = dataOut;
        end
    end

    task automatic doReset();
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
    endtask

    // One-cycle start pulse; DUT samples it on the second posedge here.
    task automatic applyStimulus();
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
    endtask

    task automatic runToHalt(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!halted) checkOutput("halt_timeout", 32'(halted), 32'd1);
    endtask

    task automatic clearRom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    initial begin
        int cyc;
        logic found;
        logic wrapped;
        logic dropped;
        logic [3:0] prev;

        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        logic found;
        logic wrapped;
        logic dropped;
        logic [3:0] prev;

        // Test 1: reset mid-EXECUTE of ADDI.
        clearRom();
        rom[0] = 8'h12; rom[1] = 8'h23; rom[2] = 8'h50; rom[3] = 8'hF0;
        doReset();
        checkOutput("reset_running", 32'(running), 32'd0);
        checkOutput("reset_rom_addr", 32'(rom_addr), 32'd0);
        applyStimulus();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #1;
            if (loadAcu && dataIn == 4'd3) found = 1'b1;
        end
        checkOutput("t1_reached_addi", 32'(found), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("t1_loadAcu_abort", 32'(loadAcu), 32'd0);
        checkOutput("t1_dataIn_abort", 32'(dataIn), 32'd0);
        checkOutput("t1_control_abort", 32'(control), 32'd0);
        checkOutput("t1_running_abort", 32'(running), 32'd0);
        checkOutput("t1_rom_addr_abort", 32'(rom_addr), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("t1_idle_running", 32'(running), 32'd0);
        checkOutput("t1_idle_halted", 32'(halted), 32'd0);
        checkOutput("t1_idle_rom_addr", 32'(rom_addr), 32'd0);

        // Test 2: LDI 15; ADDI 6; OUT; HALT -> 5 with carry, halted after 12 cycles.
        clearRom();
        rom[0] = 8'h1F; rom[1] = 8'h26; rom[2] = 8'h50; rom[3] = 8'hF0;
        doReset();
        applyStimulus();
        runToHalt(40, cyc);
        checkOutput("t2_halt_cycles", 32'(cyc), 32'd12);
        checkOutput("t2_out_seen", 32'(out_seen), 32'd1);
        checkOutput("t2_dataOut", 32'(out_val), 32'd5);
        checkOutput("t2_model_cf", 32'(m_cf), 32'd1);
        checkOutput("t2_halt_addr", 32'(rom_addr), 32'd3);

        // Test 3: zero flag jump taken.
        clearRom();
        rom[0] = 8'h16; rom[1] = 8'h36; rom[2] = 8'h75; rom[3] = 8'h11;
        rom[4] = 8'hF0; rom[5] = 8'h50; rom[6] = 8'hF0;
        doReset();
        applyStimulus();
        runToHalt(60, cyc);
        checkOutput("t3_model_zf", 32'(m_zf), 32'd1);
        checkOutput("t3_out_seen", 32'(out_seen), 32'd1);
        checkOutput("t3_dataOut", 32'(out_val), 32'd0);
        checkOutput("t3_halt_addr", 32'(rom_addr), 32'd6);

        // Test 4: carry clear, JC falls through.
        clearRom();
        rom[0] = 8'h13; rom[1] = 8'h21; rom[2] = 8'h60; rom[3] = 8'h50; rom[4] = 8'hF0;
        doReset();
        applyStimulus();
        runToHalt(60, cyc);
        checkOutput("t4_out_seen", 32'(out_seen), 32'd1);
        checkOutput("t4_dataOut", 32'(out_val), 32'd4);
        checkOutput("t4_halt_addr", 32'(rom_addr), 32'd4);

        // Test 5: NOPs then JMP 0 at 15; then a pure increment wrap.
        for (int v = 0; v < 2; v++) begin
            clearRom();
            if (v == 0) rom[15] = 8'h80;
            doReset();
            applyStimulus();
            wrapped = 1'b0;
            dropped = 1'b0;
            prev    = rom_addr;
            for (int i = 0; i < 70; i++) begin
                @(posedge clk);
                #1;
                if (prev == 4'd15 && rom_addr == 4'd0) wrapped = 1'b1;
                if (!running) dropped = 1'b1;
                prev = rom_addr;
            end
            checkOutput(v == 0 ? "t5_jmp_wrap" : "t5_inc_wrap", 32'(wrapped), 32'd1);
            checkOutput(v == 0 ? "t5_jmp_running" : "t5_inc_running", 32'(dropped), 32'd0);
        end

        // Test 6: NANDI, with start pulses during the run.
        clearRom();
        rom[0] = 8'h1A; rom[1] = 8'h48; rom[2] = 8'h50; rom[3] = 8'hF0;
        doReset();
        applyStimulus();
        for (int p = 0; p < 2; p++) begin
            repeat (3) @(posedge clk);
            #2 start = 1'b1;
            @(posedge clk);
            #2 start = 1'b0;
        end
        runToHalt(40, cyc);
        checkOutput("t6_out_seen", 32'(out_seen), 32'd1);
        checkOutput("t6_dataOut", 32'(out_val), 32'd7);
        checkOutput("t6_model_acc", 32'(m_acc), 32'd7);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t6_halt_sticky", 32'(halted), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
